alu_dsp_arbiter: RTL and testbench

- Shares one combinational DSP add/sub unit (input1, input2, addsub, out) between two requesters: req0 = ALU execute path, req1 = branch-target / PC-offset adder.
- Round-robin arbitration, valid/ready handshake per requester, single registered result slot with back-pressure.
- Sits between the core datapath and the adder_dsp instance, which it drives directly.

---
 rtl/alu_dsp_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_dsp_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_dsp_arbiter.sv
// Round-robin arbiter sharing one combinational DSP add/sub unit between two requesters,
// with a single registered result slot. Define SAIL_ALU_ARB_FIXED_PRIORITY_EN for fixed priority.
module alu_dsp_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 req0_valid_i,
  output logic                 req0_ready_o,
  input  logic [WIDTH-1:0]     req0_a_i,
  input  logic [WIDTH-1:0]     req0_b_i,
  input  logic                 req0_sub_i,

  input  logic                 req1_valid_i,
  output logic                 req1_ready_o,
  input  logic [WIDTH-1:0]     req1_a_i,
  input  logic [WIDTH-1:0]     req1_b_i,
  input  logic                 req1_sub_i,

  output logic                 resp0_valid_o,
  output logic                 resp1_valid_o,
  input  logic                 resp0_ready_i,
  input  logic                 resp1_ready_i,
  output logic [WIDTH-1:0]     resp_data_o,

  output logic [WIDTH-1:0]     dsp_in1_o,
  output logic [WIDTH-1:0]     dsp_in2_o,
  output logic                 dsp_addsub_o,
  input  logic [WIDTH-1:0]     dsp_out_i,

  output logic [CNT_WIDTH-1:0] contention_cnt_o
);

  typedef enum logic [1:0] {StEmpty, StFull0, StFull1} slot_e;

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  slot_e                slot_q, slot_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic prio1;
  logic grant0, grant1;
  logic slot_free;
  logic accept0, accept1;

`ifdef SAIL_ALU_ARB_FIXED_PRIORITY_EN
  assign prio1 = 1'b0;
`else
  logic rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (accept0) begin
      rr_d = 1'b1;
    end else if (accept1) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign prio1 = rr_q;
`endif

  assign grant0 = req0_valid_i & (~req1_valid_i | ~prio1);
  assign grant1 = req1_valid_i & ~grant0;

  // A full slot is free when its owner drains it this cycle, allowing back-to-back refill.
  always_comb begin
    slot_free = 1'b1;
    unique case (slot_q)
      StEmpty: slot_free = 1'b1;
      StFull0: slot_free = resp0_ready_i;
      StFull1: slot_free = resp1_ready_i;
      default: slot_free = 1'b1;
    endcase
  end

  assign accept0 = grant0 & slot_free & ~rst_i;
  assign accept1 = grant1 & slot_free & ~rst_i;

  // Slot state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= StEmpty;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  // Slot next state
  always_comb begin
    slot_d = slot_q;
    data_d = data_q;
    if (accept0) begin
      slot_d = StFull0;
      data_d = dsp_out_i;
    end else if (accept1) begin
      slot_d = StFull1;
      data_d = dsp_out_i;
    end else if (slot_free) begin
      slot_d = StEmpty;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (req0_valid_i && req1_valid_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // Outputs; DSP inputs are held at zero outside accept cycles to avoid toggling.
  always_comb begin
    req0_ready_o  = accept0;
    req1_ready_o  = accept1;
    resp0_valid_o = (slot_q == StFull0);
    resp1_valid_o = (slot_q == StFull1);
    resp_data_o   = data_q;
    dsp_in1_o     = '0;
    dsp_in2_o     = '0;
    dsp_addsub_o  = 1'b0;
    if (accept0) begin
      dsp_in1_o    = req0_a_i;
      dsp_in2_o    = req0_b_i;
      dsp_addsub_o = req0_sub_i;
    end else if (accept1) begin
      dsp_in1_o    = req1_a_i;
      dsp_in2_o    = req1_b_i;
      dsp_addsub_o = req1_sub_i;
    end
    contention_cnt_o = cnt_q;
  end

endmodule

// File: tb/tb_alu_dsp_arbiter.sv
// Scoreboard bench for alu_dsp_arbiter with a behavioural DSP adder and a reference model
// of arbitration, slot occupancy and the saturating contention counter.
module tb_alu_dsp_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req0_sub;
  logic [W-1:0]  req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_sub;
  logic [W-1:0]  req1_a, req1_b;
  logic          resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [W-1:0]  resp_data;
  logic [W-1:0]  dsp_in1, dsp_in2, dsp_out;
  logic          dsp_addsub;
  logic [CW-1:0] contention_cnt;

  alu_dsp_arbiter #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req0_valid_i     (req0_valid),
    .req0_ready_o     (req0_ready),
    .req0_a_i         (req0_a),
    .req0_b_i         (req0_b),
    .req0_sub_i       (req0_sub),
    .req1_valid_i     (req1_valid),
    .req1_ready_o     (req1_ready),
    .req1_a_i         (req1_a),
    .req1_b_i         (req1_b),
    .req1_sub_i       (req1_sub),
    .resp0_valid_o    (resp0_valid),
    .resp1_valid_o    (resp1_valid),
    .resp0_ready_i    (resp0_ready),
    .resp1_ready_i    (resp1_ready),
    .resp_data_o      (resp_data),
    .dsp_in1_o        (dsp_in1),
    .dsp_in2_o        (dsp_in2),
    .dsp_addsub_o     (dsp_addsub),
    .dsp_out_i        (dsp_out),
    .contention_cnt_o (contention_cnt)
  );

  assign dsp_out = dsp_addsub ? dsp_in1 - dsp_in2 : dsp_in1 + dsp_in2;

  always #5 clk = ~clk;

  typedef struct {
    bit           owner;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   m_full, m_owner, m_rr;
  int   m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1; drives one cycle, checks comb outputs at negedge, state after edge.
  task automatic cycle(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input bit s0, input bit v1, input logic [W-1:0] a1,
                       input logic [W-1:0] b1, input bit s1, input bit r0, input bit r1);
    bit free, g0, g1, acc0, acc1, cons;
    exp_t e;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
    resp0_ready = r0; resp1_ready = r1;
    @(negedge clk);
    free = !m_full || (m_owner ? r1 : r0);
`ifdef SAIL_ALU_ARB_FIXED_PRIORITY_EN
    g0 = v0;
`else
    g0 = v0 && (!v1 || !m_rr);
`endif
    g1 = v1 && !g0;
    acc0 = g0 && free;
    acc1 = g1 && free;
    check("req0_ready", 64'(req0_ready), 64'(acc0));
    check("req1_ready", 64'(req1_ready), 64'(acc1));
    if (acc0) begin
      check("dsp_in1", 64'(dsp_in1), 64'(a0));
      check("dsp_in2", 64'(dsp_in2), 64'(b0));
      check("dsp_addsub", 64'(dsp_addsub), 64'(s0));
    end else if (acc1) begin
      check("dsp_in1", 64'(dsp_in1), 64'(a1));
      check("dsp_in2", 64'(dsp_in2), 64'(b1));
      check("dsp_addsub", 64'(dsp_addsub), 64'(s1));
    end else begin
      check("dsp_idle", {31'd0, dsp_addsub, dsp_in1 | dsp_in2}, 64'd0);
    end
    cons = m_full && (m_owner ? r1 : r0);
    if (m_full) begin
      check("resp0_valid", 64'(resp0_valid), 64'(!m_owner));
      check("resp1_valid", 64'(resp1_valid), 64'(m_owner));
      if (sb.size() > 0) check("resp_data", 64'(resp_data), 64'(sb[0].data));
      else check("sb_nonempty", 64'(sb.size()), 64'd1);
    end else begin
      check("resp_idle", {62'd0, resp0_valid, resp1_valid}, 64'd0);
    end
    if (cons && sb.size() > 0) void'(sb.pop_front());
    if (acc0 || acc1) begin
      e.owner = acc1;
      if (acc0) e.data = s0 ? a0 - b0 : a0 + b0;
      else      e.data = s1 ? a1 - b1 : a1 + b1;
      sb.push_back(e);
      m_full = 1'b1;
      m_owner = acc1;
      m_rr = !acc1;
    end else if (cons) begin
      m_full = 1'b0;
    end
    if (v0 && v1 && m_cnt < (1 << CW) - 1) m_cnt++;
    @(posedge clk);
    #1;
    check("contention_cnt", 64'(contention_cnt), 64'(m_cnt));
    check("resp_valid_post", {62'd0, resp0_valid, resp1_valid},
          m_full ? (m_owner ? 64'd1 : 64'd2) : 64'd0);
    if (m_full && sb.size() > 0) check("resp_data_post", 64'(resp_data), 64'(sb[$].data));
  endtask

  task automatic idle(input bit r0, input bit r1);
    cycle(0, '0, '0, 0, 0, '0, '0, 0, r0, r1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    m_full = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
    #2;
    check("rst_resp_valid", {62'd0, resp0_valid, resp1_valid}, 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_cnt", 64'(contention_cnt), 64'd0);
    check("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single add, then subtract wrap
    cycle(1, 32'd5, 32'd7, 0, 0, '0, '0, 0, 1, 1);
    idle(1, 1);
    cycle(0, '0, '0, 0, 1, 32'd0, 32'd1, 1, 1, 1);
    idle(1, 1);

    // Contention, both drained every cycle
    for (int i = 0; i < 4; i++)
      cycle(1, 32'(100 + i), 32'(i), i[0], 1, 32'(200 + i), 32'(3 * i), 1, 1, 1);
    idle(1, 1);

    // Back-pressure on owner 0 while requester 1 waits
    cycle(1, 32'd10, 32'd3, 1, 0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, '0, '0, 0, 1, 32'd100, 32'd1, 0, 0, 1);
    cycle(0, '0, '0, 0, 1, 32'd100, 32'd1, 0, 1, 1);
    idle(1, 1);

    // Counter saturation
    for (int i = 0; i < 20; i++)
      cycle(1, $urandom, $urandom, 1'($urandom), 1, $urandom, $urandom, 1'($urandom), 1, 1);
    idle(1, 1);

    // Reset while a result is pending
    cycle(1, 32'd3, 32'd4, 0, 0, '0, '0, 0, 0, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_resp_valid", {62'd0, resp0_valid, resp1_valid}, 64'd0);
    check("midrst_resp_data", 64'(resp_data), 64'd0);
    check("midrst_cnt", 64'(contention_cnt), 64'd0);
    check("midrst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    m_full = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
    sb.delete();
    @(posedge clk); #1;
    cycle(1, 32'd8, 32'd2, 0, 1, 32'd9, 32'd9, 1, 1, 1);
    idle(1, 1);
    cycle(0, '0, '0, 0, 1, 32'd1, 32'd2, 0, 1, 1);
    idle(1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
